// File: rtl/nr_recip_engine.sv
// Sequential Newton-Raphson reciprocal: linear seed plus ITERS refinements on shared multipliers.
// Optional NR_EARLY_EXIT_EN: stop refining as soon as the error term E equals exactly 1.0.
module nr_recip_engine #(
    parameter int unsigned SIZE  = 16,
    parameter int unsigned ITERS = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] num,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*SIZE-1:0] out_recip,
    output logic            out_err
);

    localparam int unsigned W  = 2 * SIZE;
    localparam int unsigned W2 = 2 * W;
    localparam int unsigned WX = W + 2;
    localparam int unsigned PW = W + SIZE;
    localparam int unsigned CW = 2 * SIZE + 6;

    // Seed line 48/17 - 32/17*d in 2.(W-2), derived at extra width to avoid overflow
    localparam logic [CW-1:0] ONE_CW = CW'(1) << (W - 2);
    localparam logic [W-1:0]  C1     = W'((CW'(48) * ONE_CW) / CW'(17));
    localparam logic [W-1:0]  C2     = W'((CW'(32) * ONE_CW) / CW'(17));
    localparam logic [W-1:0]  TWO    = W'(1) << (W - 1);
    localparam logic [3:0]    LAST   = 4'(ITERS - 1);
`ifdef NR_EARLY_EXIT_EN
    localparam logic [W-1:0]  ONE    = W'(1) << (W - 2);
`endif

    if (ITERS == 0 || ITERS > 15) begin : g_iters_bad
        $error("nr_recip_engine: ITERS must be in 1..15");
    end

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        MUL_A,
        MUL_B,
        DONE
    } state_t;

    state_t          state;
    logic [SIZE-1:0] d_q;
    logic [W-1:0]    x_q;
    logic [W-1:0]    e_q;
    logic [3:0]      cnt;
    logic            err_q;

    logic [W-1:0]    seed_c;
    logic [W-1:0]    p_c;
    logic [W-1:0]    e_c;
    logic [WX-1:0]   mulb_wide;
    logic [W-1:0]    mulb_c;

    // Shared datapath: seed, d*x product, error term, and the saturating x*E update
    assign seed_c    = C1 - W'((PW'(C2) * PW'(d_q)) >> SIZE);
    assign p_c       = W'((PW'(d_q) * PW'(x_q)) >> SIZE);
    assign e_c       = TWO - p_c;
    assign mulb_wide = WX'((W2'(x_q) * W2'(e_q)) >> (W - 2));
    assign mulb_c    = (|mulb_wide[WX-1:W]) ? {W{1'b1}} : mulb_wide[W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_recip <= '0;
            out_err   <= 1'b0;
            cnt       <= '0;
            d_q       <= '0;
            x_q       <= '0;
            e_q       <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d_q      <= num;
                        in_ready <= 1'b0;
                        if (!num[SIZE-1]) begin
                            x_q   <= '1;
                            err_q <= 1'b1;
                            state <= DONE;
                        end else begin
                            err_q <= 1'b0;
                            state <= SEED;
                        end
                    end
                end
                SEED: begin
                    x_q   <= seed_c;
                    cnt   <= '0;
                    state <= MUL_A;
                end
                MUL_A: begin
                    e_q <= e_c;
`ifdef NR_EARLY_EXIT_EN
                    // x is already a fixed point of the iteration; further passes change nothing
                    state <= (e_c == ONE) ? DONE : MUL_B;
`else
                    state <= MUL_B;
`endif
                end
                MUL_B: begin
                    x_q   <= mulb_c;
                    cnt   <= cnt + 4'd1;
                    state <= (cnt == LAST) ? DONE : MUL_A;
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                        out_recip <= x_q;
                        out_err   <= err_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/nr_recip_engine.md
Name: nr_recip_engine

Overview:
- Sequential fixed-point reciprocal unit for the PPU divide path.
- Accepts a normalised divisor mantissa, generates a linear seed and runs ITERS Newton-Raphson refinements x <- x*(2 - d*x).
- Computes each refinement over two cycles on shared multipliers, then presents the reciprocal to the posit divide/normalise stage.
- Valid/ready handshake on both sides; one operation in flight.

Parameters:
- SIZE, 16, divisor mantissa width.
- ITERS, 3, number of Newton-Raphson refinements (1..15).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  num is valid.
- in_ready  output  1  engine can accept num.
- num  input  SIZE  divisor mantissa d = num/2^SIZE, unsigned 0.SIZE format, MSB must be 1 (d in [0.5,1)).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_recip  output  2*SIZE  1/d, unsigned 2.(2*SIZE-2) format.
- out_err  output  1  num was zero or unnormalised (MSB clear).

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_recip=0, out_err=0, state=IDLE, iteration counter=0.
- Fixed-point rules:
  - X (iterate) is 2*SIZE bits, 2.(2*SIZE-2) format.
  - C1=floor(48/17*2^(2*SIZE-2)), C2=floor(32/17*2^(2*SIZE-2)); constants computed at width >= 2*SIZE+6.
  - SEED: X = C1 - ((C2*num) >> SIZE).
  - MUL_A: P = (num*X) >> SIZE (truncate, 2.(2*SIZE-2)); E = 2.0 - P (2.0 = 1<<(2*SIZE-1)).
  - MUL_B: X = (X*E) >> (2*SIZE-2), truncated. If any discarded high bit is set, X saturates to all-ones.
- FSM states: IDLE, SEED, MUL_A, MUL_B, DONE.
  - IDLE: in_ready=1. On in_valid: latch num. If num[SIZE-1]==0, go to DONE with out_recip=all-ones and out_err=1; otherwise go to SEED.
  - SEED: compute X, clear counter, go to MUL_A.
  - MUL_A: register E, go to MUL_B.
  - MUL_B: update X and increment counter. Go to DONE if counter == ITERS-1 before increment, else go to MUL_A.
  - DONE: out_valid=1, out_recip=X, out_err=0 (valid path). Outputs stay stable until out_ready. On out_valid & out_ready, go to IDLE and drop out_valid the next cycle.
- Latency:
  - Accept at edge k; out_valid rises after edge k+2+2*ITERS (edge k+8 for ITERS=3).
  - Error path: out_valid rises after edge k+1.
- in_ready is low in every state except IDLE. No new input is accepted in the cycle a result is consumed; the next accept is possible the following cycle.
- in_valid while busy is ignored and not buffered. num may change freely after the accept edge.
- out_ready held high before DONE has no effect.
- rst mid-operation discards the operation and restores reset values on the next edge; the counter is cleared.
- Counter width is 4 bits; ITERS outside 1..15 is an elaboration error ($error).

Optional Feature:
- Macro NR_EARLY_EXIT_EN.
- Defined: in MUL_A, if E == 1.0 exactly (1<<(2*SIZE-2)), skip MUL_B and go straight to DONE, since X is a fixed point. Latency may be shorter than 2+2*ITERS; out_recip must equal a golden model applying the same exit rule.
- Undefined: always runs exactly ITERS iterations with fixed latency.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, out_recip=0, out_err=0; no accept during reset.
- SIZE=16, ITERS=3, num=0xC000 (d=0.75), out_ready=1 -> out_valid exactly 8 cycles after accept; out_recip within 8 ulp below 0x55555555; out_err=0.
- num=0x8000 -> out_recip within 8 ulp below 0x80000000. num=0xFFFF -> within 8 ulp below 0x40004000.
- num=0x0000, then num=0x4000 -> each gives out_valid 1 cycle after accept, out_recip=0xFFFFFFFF, out_err=1.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid/out_recip stable, in_ready=0, new in_valid ignored. Raise out_ready -> one transfer, then in_ready=1 next cycle.
- Reset mid-op: rst on 4th cycle after accepting 0xC000 -> no out_valid follows. A new accept of 0xA000 afterwards yields out_recip within 8 ulp below 0x66666666 at the normal latency.
